// File: rtl/multicycle_cpu_ctrl_if.sv
// Bus bundle between the multi-cycle sequencer and its datapath, decoder and memories.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_cpu_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc;
  logic            is_load;
  logic            is_store;
  logic            is_halt;
  logic            reg_we;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] store_data;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            rf_we;
  logic [XLEN-1:0] wb_data;
  logic            halted;
  logic            trap;

  modport master (
    output imem_req, imem_addr, ir, pc,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output rf_we, wb_data, halted, trap,
    input  imem_ack, imem_rdata,
    input  is_load, is_store, is_halt, reg_we,
    input  alu_result, npc, store_data,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, ir, pc,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  rf_we, wb_data, halted, trap,
    output imem_ack, imem_rdata,
    output is_load, is_store, is_halt, reg_we,
    output alu_result, npc, store_data,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_cpu_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core; owns PC, IR and staging registers.
// Optional PERF_CNT_EN macro adds cycle_cnt / instret_cnt outputs.
module multicycle_cpu_ctrl #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int unsigned      MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_cpu_ctrl_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [63:0]          cycle_cnt,
  output logic [63:0]          instret_cnt
`endif
);

  localparam int unsigned WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   npc_q, npc_d;
  logic [XLEN-1:0]   sd_q, sd_d;
  logic [XLEN-1:0]   ld_q, ld_d;
  logic              ld_flag_q, ld_flag_d;
  logic              st_flag_q, st_flag_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              halted_q, halted_d;
  logic              trap_q, trap_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_we_q, rf_we_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              timed_out;

  // State and staging registers; the reset state is FETCH, so the fetch request is up from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      alu_q      <= '0;
      npc_q      <= '0;
      sd_q       <= '0;
      ld_q       <= '0;
      ld_flag_q  <= 1'b0;
      st_flag_q  <= 1'b0;
      wait_q     <= '0;
      wb_data_q  <= '0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      alu_q      <= alu_d;
      npc_q      <= npc_d;
      sd_q       <= sd_d;
      ld_q       <= ld_d;
      ld_flag_q  <= ld_flag_d;
      st_flag_q  <= st_flag_d;
      wait_q     <= wait_d;
      wb_data_q  <= wb_data_d;
      halted_q   <= halted_d;
      trap_q     <= trap_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
    end
  end

  // Saturating wait count for the cycle in progress if it goes unacknowledged.
  assign wait_inc  = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
  assign timed_out = TIMEOUT_EN && (wait_inc == WAIT_LIM);

  // Next-state and staging logic; strobes are registered off the next state so they align with it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    npc_d     = npc_q;
    sd_d      = sd_q;
    ld_d      = ld_q;
    ld_flag_d = ld_flag_q;
    st_flag_d = st_flag_q;
    wait_d    = wait_q;
    halted_d  = halted_q;
    trap_d    = trap_q;

    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          wait_d  = '0;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_inc;
          if (timed_out) begin
            trap_d  = 1'b1;
            state_d = S_TRAP;
          end
        end
      end
      S_DECODE: begin
        if (bus.is_halt) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d     = bus.alu_result;
        npc_d     = bus.npc;
        sd_d      = bus.store_data;
        ld_flag_d = bus.is_load;
        // A word flagged as both load and store is executed as a load.
        st_flag_d = bus.is_store & ~bus.is_load;
        wait_d    = '0;
        state_d   = (bus.is_load | bus.is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (ld_flag_q) ld_d = bus.dmem_rdata;
          wait_d  = '0;
          state_d = S_WB;
        end else begin
          wait_d = wait_inc;
          if (timed_out) begin
            trap_d  = 1'b1;
            state_d = S_TRAP;
          end
        end
      end
      S_WB: begin
        pc_d    = npc_q;
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) & st_flag_d;
    rf_we_d    = (state_d == S_WB) & bus.reg_we & ~st_flag_d;
    wb_data_d  = wb_data_q;
    if (state_d == S_WB) wb_data_d = ld_flag_d ? ld_d : alu_d;
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.ir         = ir_q;
  assign bus.pc         = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = sd_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.halted     = halted_q;
  assign bus.trap       = trap_q;

`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt_q;
  logic [63:0] instret_cnt_q;

  // Cycle count freezes once terminal; instret counts write-back cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_HALT && state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + 64'd1;
      if (state_q == S_WB) instret_cnt_q <= instret_cnt_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_cpu_ctrl.sv
// Directed bench for multicycle_cpu_ctrl: table of instruction transactions plus reset, halt and timeout sequences.
module tb_multicycle_cpu_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_cpu_ctrl_if #(.XLEN(32)) bus ();

`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
`endif

  multicycle_cpu_ctrl #(
    .XLEN        (32),
    .RESET_PC    (32'h0),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic        ld;
    logic        st;
    logic        we;
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          iwait;
    int          dwait;
    bit          spur;
    int          exp_cyc;
    int          exp_rfw;
    logic [31:0] exp_wb;
    int          exp_dreq;
    logic        exp_dwe;
  } vec_t;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] cur_pc = 32'h0;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.is_halt  = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    cur_pc = 32'h0;
  endtask

  // Runs one instruction from its first FETCH cycle up to the first cycle of the next FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    int          cyc = 0, iw = 0, dw = 0, dreq = 0, rfw = 0, rf_cyc = 0;
    bit          left = 1'b0, ok = 1'b0;
    logic        dwe = 1'b0;
    logic [31:0] wbd = '0, daddr = '0, dwd = '0;
    bus.is_load    = v.ld;
    bus.is_store   = v.st;
    bus.reg_we     = v.we;
    bus.is_halt    = 1'b0;
    bus.alu_result = v.alu;
    bus.npc        = v.npc;
    bus.store_data = v.sd;
    chk($sformatf("v%0d imem_addr", idx), bus.imem_addr, cur_pc);
    while (cyc < 64) begin
      if (bus.imem_req && left) begin
        ok = 1'b1;
        break;
      end
      cyc++;
      bus.imem_ack   = 1'b0;
      bus.dmem_ack   = 1'b0;
      bus.imem_rdata = 32'hBAD0_BAD0;
      bus.dmem_rdata = 32'hBAD1_BAD1;
      if (bus.imem_req) begin
        if (iw == v.iwait) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = v.instr;
        end else iw++;
      end else begin
        left = 1'b1;
        if (v.spur) bus.imem_ack = 1'b1;
      end
      if (bus.dmem_req) begin
        dreq++;
        dwe   = dwe | bus.dmem_we;
        daddr = bus.dmem_addr;
        dwd   = bus.dmem_wdata;
        if (dw == v.dwait) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = v.rdata;
        end else dw++;
      end else if (v.spur) bus.dmem_ack = 1'b1;
      if (bus.rf_we) begin
        rfw++;
        rf_cyc = cyc;
        wbd    = bus.wb_data;
      end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    chk($sformatf("v%0d completed", idx), 64'(ok), 64'd1);
    chk($sformatf("v%0d cycles", idx), 64'(cyc), 64'(v.exp_cyc));
    chk($sformatf("v%0d rf_we pulses", idx), 64'(rfw), 64'(v.exp_rfw));
    if (v.exp_rfw != 0) begin
      chk($sformatf("v%0d wb_data", idx), wbd, v.exp_wb);
      chk($sformatf("v%0d rf_we cycle", idx), 64'(rf_cyc), 64'(v.exp_cyc));
    end
    chk($sformatf("v%0d dmem_req cycles", idx), 64'(dreq), 64'(v.exp_dreq));
    if (v.exp_dreq != 0) begin
      chk($sformatf("v%0d dmem_we", idx), dwe, v.exp_dwe);
      chk($sformatf("v%0d dmem_addr", idx), daddr, v.alu);
      if (v.exp_dwe) chk($sformatf("v%0d dmem_wdata", idx), dwd, v.sd);
    end
    chk($sformatf("v%0d ir", idx), bus.ir, v.instr);
    chk($sformatf("v%0d next pc", idx), bus.pc, v.npc);
    cur_pc = v.npc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    int   n;
    //          instr          ld st we alu           npc           sd            rdata         iw dw sp cyc rfw wb            dreq dwe
    tbl[0] = '{32'h0050_0093, 0, 0, 1, 32'h0000_0005, 32'h0000_0004, 32'h0,        32'h0,        0, 0, 0, 4, 1, 32'h0000_0005, 0, 0};
    tbl[1] = '{32'h2000_2103, 1, 0, 1, 32'h0000_0200, 32'h0000_0008, 32'h0,        32'hDEAD_BEEF, 0, 3, 1, 8, 1, 32'hDEAD_BEEF, 4, 0};
    tbl[2] = '{32'h1030_2023, 0, 1, 0, 32'h0000_0100, 32'h0000_000C, 32'h0000_1234, 32'h0,       0, 0, 0, 5, 0, 32'h0,        1, 1};
    tbl[3] = '{32'h1030_2023, 0, 1, 1, 32'h0000_0104, 32'h0000_0010, 32'h0000_5678, 32'h0,       1, 2, 1, 8, 0, 32'h0,        3, 1};
    tbl[4] = '{32'h0000_0463, 0, 0, 0, 32'h0000_0000, 32'h0000_0018, 32'h0,        32'h0,        2, 0, 0, 6, 0, 32'h0,        0, 0};
    tbl[5] = '{32'h0040_00EF, 0, 0, 1, 32'h0000_001C, 32'h0000_001C, 32'h0,        32'h0,        1, 0, 1, 5, 1, 32'h0000_001C, 0, 0};
    tbl[6] = '{32'h0000_2003, 1, 1, 1, 32'h0000_0300, 32'hFFFF_FFFC, 32'h0000_AAAA, 32'hCAFE_F00D, 0, 1, 1, 6, 1, 32'hCAFE_F00D, 2, 0};
    tbl[7] = '{32'h0010_0093, 0, 0, 1, 32'h0000_0001, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 4, 1, 32'h0000_0001, 0, 0};

    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.is_halt    = 1'b0;
    bus.reg_we     = 1'b0;
    bus.alu_result = 32'h0;
    bus.npc        = 32'h0;
    bus.store_data = 32'h0;

    // Reset held three cycles with imem_ack tied high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst pc", bus.pc, 32'h0);
      chk("rst ir", bus.ir, 32'h0);
      chk("rst dmem_req/rf_we/halted/trap", {bus.dmem_req, bus.rf_we, bus.halted, bus.trap}, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    chk("post-rst imem_req", bus.imem_req, 1'b1);
    chk("post-rst imem_addr", bus.imem_addr, 32'h0);
    chk("post-rst ir before ack", bus.ir, 32'h0);
    @(negedge clk);
    chk("first ack latches ir", bus.ir, 32'h0050_0093);
    chk("imem_req drops after ack", bus.imem_req, 1'b0);

    reset_dut();
    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // Reset while a load waits in MEM: request drops and a late ack is ignored.
    bus.is_load    = 1'b1;
    bus.is_store   = 1'b0;
    bus.reg_we     = 1'b1;
    bus.alu_result = 32'h0000_0040;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0400_2183;
    n = 0;
    while (!bus.dmem_req && n < 10) begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      n++;
    end
    chk("mid-reset reached MEM", bus.dmem_req, 1'b1);
    rst            = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("mid-reset dmem_req dropped", bus.dmem_req, 1'b0);
    chk("mid-reset pc", bus.pc, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("late ack ignored dmem_req", bus.dmem_req, 1'b0);
    chk("late ack ignored rf_we", bus.rf_we, 1'b0);
    chk("after mid-reset imem_req", bus.imem_req, 1'b1);
    bus.dmem_ack = 1'b0;

    // Two ALU ops then halt.
    reset_dut();
    run_vec(100, tbl[0]);
    hv     = tbl[0];
    hv.npc = 32'h0000_0008;
    run_vec(101, hv);
    bus.is_halt    = 1'b1;
    bus.reg_we     = 1'b0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0010_0073;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    chk("halt halted", bus.halted, 1'b1);
    chk("halt pc", bus.pc, 32'h8);
    chk("halt imem_req", bus.imem_req, 1'b0);
`ifdef PERF_CNT_EN
    chk("halt cycle_cnt", cycle_cnt, 64'd10);
    chk("halt instret_cnt", instret_cnt, 64'd2);
`endif
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("halt sticky", {bus.halted, bus.trap}, 2'b10);
    chk("halt no strobes", {bus.imem_req, bus.dmem_req, bus.rf_we}, 3'b000);
    chk("halt pc frozen", bus.pc, 32'h8);
`ifdef PERF_CNT_EN
    chk("halt cycle_cnt frozen", cycle_cnt, 64'd10);
`endif

    // Fetch timeout.
    reset_dut();
    bus.is_halt = 1'b0;
    n = 0;
    while (bus.imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("fetch timeout req cycles", 64'(n), 64'd15);
    chk("fetch timeout trap", bus.trap, 1'b1);
    chk("fetch timeout pc", bus.pc, 32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_2222;
    repeat (3) @(negedge clk);
    chk("trap sticky", {bus.trap, bus.halted, bus.imem_req}, 3'b100);
    chk("trap ignores ack", bus.ir, 32'h0);
    bus.imem_ack = 1'b0;

    // Data-side timeout on a load.
    reset_dut();
    bus.is_load    = 1'b1;
    bus.is_store   = 1'b0;
    bus.reg_we     = 1'b1;
    bus.alu_result = 32'h0000_0400;
    bus.npc        = 32'h0000_0004;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h4000_2203;
    n = 0;
    while (!bus.dmem_req && n < 10) begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      n++;
    end
    n = 0;
    while (bus.dmem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("dmem timeout req cycles", 64'(n), 64'd15);
    chk("dmem timeout trap", bus.trap, 1'b1);
    chk("dmem timeout pc", bus.pc, 32'h0);
    chk("dmem timeout rf_we", bus.rf_we, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
